lsu_data_memory: RTL

Parametrised, byte-addressed RV32I data memory with a valid/ready request/response handshake. It replaces the free-running combinational-read memory in the load/store path.
- Supports all RV32I load and store widths through funct3.
- Registers read data with one-cycle latency.
- Reports misaligned, out-of-range and illegal-funct3 accesses as faults instead of silently corrupting memory.
- Sits between the execute/memory stage and writeback.

---
 rtl/lsu_data_memory.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : lsu_data_memory
// Purpose  : Byte-addressed RV32I data memory for the load/store path, with a
//            valid/ready request/response handshake. Handles every RV32I load
//            and store width, registers load data with one cycle of latency,
//            and reports misaligned, out-of-range and illegal-funct3 requests
//            as faults without touching memory.
// Ports    : clk, rst_n                 clock, asynchronous active-low reset
//            req_valid / req_ready      request handshake
//            req_write, req_funct3      1 = store; RV32I width/extension code
//            req_addr, req_wdata        byte address, store data (low bytes
//                                       used for B/H)
//            rsp_valid / rsp_ready      response handshake
//            rsp_rdata, rsp_fault       extended load data (0 for stores and
//                                       faults), fault flag
// Params   : ADDR_WIDTH  byte-address bits implemented (legal 4..20)
// Revision : 1.0  initial release
// ============================================================================
module lsu_data_memory #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam int c_index_w = ADDR_WIDTH - 2;
  localparam int c_depth   = 1 << c_index_w;

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_resp = 1'b1;

  logic [0:0]           r_state;
  logic [0:0]           w_state_next;
  logic                 w_accept;
  logic                 w_range_fault;
  logic                 w_funct3_fault;
  logic                 w_align_fault;
  logic                 w_fault;
  logic                 w_mem_we;
  logic [c_index_w-1:0] w_index;
  logic [3:0]           w_byte_en;
  logic [31:0]          w_word;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [31:0]          w_load_data;

  // A request arriving while reset is held must never commit a store, even
  // though the idle state advertises readiness.
  assign w_accept = rst_n && req_valid && req_ready;
  assign w_index  = req_addr[ADDR_WIDTH-1:2];

  // --------------------------------------------------------------------------
  // Fault detection (purely combinational on the request)
  // --------------------------------------------------------------------------
  assign w_range_fault  = |req_addr[31:ADDR_WIDTH];
  // Stores only have B/H/W; loads additionally have BU/HU.
  assign w_funct3_fault = req_write ? (req_funct3 >= 3'd3)
                                    : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));
  // funct3[1:0]==01 covers both H and HU.
  assign w_align_fault  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3 == 3'd2) && (req_addr[1:0] != 2'b00));
  assign w_fault        = w_range_fault || w_funct3_fault || w_align_fault;

  assign w_mem_we = w_accept && req_write && !w_fault;

  always_comb begin
    w_byte_en = 4'b0000;
    case (req_funct3[1:0])
      2'b00:   w_byte_en = 4'b0001 << req_addr[1:0];
      2'b01:   w_byte_en = req_addr[1] ? 4'b1100 : 4'b0011;
      default: w_byte_en = 4'b1111;
    endcase
  end

  // --------------------------------------------------------------------------
  // Storage: four byte lanes, one word-indexed array per lane. Contents are
  // never touched by reset.
  // --------------------------------------------------------------------------
  for (genvar l = 0; l < 4; l++) begin : g_lanes
    logic [7:0] r_mem [c_depth];
    logic [7:0] w_wbyte;

    // Steer the store data so that byte 0 / half 0 of req_wdata lands in
    // whichever lane(s) the address selects.
    always_comb begin
      w_wbyte = req_wdata[l*8 +: 8];
      case (req_funct3[1:0])
        2'b00:   w_wbyte = req_wdata[7:0];
        2'b01:   w_wbyte = req_wdata[(l%2)*8 +: 8];
        default: w_wbyte = req_wdata[l*8 +: 8];
      endcase
    end

    always_ff @(posedge clk) begin
      if (w_mem_we && w_byte_en[l]) begin
        r_mem[w_index] <= w_wbyte;
      end
    end

    assign w_word[l*8 +: 8] = r_mem[w_index];
  end

  // --------------------------------------------------------------------------
  // Load extraction and extension
  // --------------------------------------------------------------------------
  always_comb begin
    w_byte = w_word[7:0];
    case (req_addr[1:0])
      2'b00: w_byte = w_word[7:0];
      2'b01: w_byte = w_word[15:8];
      2'b10: w_byte = w_word[23:16];
      2'b11: w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
    w_half = req_addr[1] ? w_word[31:16] : w_word[15:0];

    w_load_data = 32'h0;
    case (req_funct3)
      3'd0:    w_load_data = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_load_data = {{16{w_half[15]}}, w_half};
      3'd2:    w_load_data = w_word;
      3'd4:    w_load_data = {24'h0, w_byte};
      3'd5:    w_load_data = {16'h0, w_half};
      default: w_load_data = 32'h0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Response registers: loaded on every accept, held otherwise
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= 32'h0;
      rsp_fault <= 1'b0;
    end else if (w_accept) begin
      rsp_fault <= w_fault;
      rsp_rdata <= (w_fault || req_write) ? 32'h0 : w_load_data;
    end
  end

  // --------------------------------------------------------------------------
  // Handshake FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (w_accept) w_state_next = c_st_resp;
      // In RESP an accept implies rsp_ready, so this is rsp_ready && !req_valid.
      c_st_resp: if (rsp_ready && !w_accept) w_state_next = c_st_idle;
      default:   w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    req_ready = 1'b1;
    rsp_valid = 1'b0;
    case (r_state)
      c_st_resp: begin
        req_ready = rsp_ready;
        rsp_valid = 1'b1;
      end
      default: begin
        req_ready = 1'b1;
        rsp_valid = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
